// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment display writer.
// Holds the segment patterns (bit 0 = a .. bit 6 = g, active-high), the
// writer FSM state type, display geometry constants and the BCD digit to
// segment encoder.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int MAX_VAL    = 999999;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    BLANK,
    PENDING
  } state_e;

  // Non-decimal nibbles cannot come out of the converter; show them blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_bin2bcd.sv
// Sequential double-dabble binary to BCD converter.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (control state only)
//   start      : load value and begin a conversion (one cycle)
//   value      : unsigned binary input, sampled when start is high
//   done       : high during the cycle whose closing edge performs the final
//                iteration; bcd is valid from the following cycle on
//   bcd        : packed BCD result, digit 0 in bits [3:0]
module seven_seg_bin2bcd #(
  parameter int VAL_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [VAL_W-1:0]      value,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(VAL_W);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [VAL_W-1:0] shift_q, shift_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] adj;

  always_comb begin
    done    = run_q && (cnt_q == CNT_W'(VAL_W - 1));
    cnt_d   = cnt_q;
    run_d   = run_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    adj     = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    if (start) begin
      shift_d = value;
      bcd_d   = '0;
      cnt_d   = '0;
      run_d   = 1'b1;
    end else if (run_q) begin
      // Add-3 correction then shift the next binary MSB into the BCD LSB.
      bcd_d   = {adj[BCD_W-2:0], shift_q[VAL_W-1]};
      shift_d = {shift_q[VAL_W-2:0], 1'b0};
      cnt_d   = cnt_q + 1'b1;
      if (done) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    bcd_q   <= bcd_d;
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/seven_seg_display_writer.sv
// Writer side of the multiplexed seven-segment display.
// A value accepted on wr_valid/wr_ready is converted to BCD, leading zeros are
// blanked and the segment patterns land in a shadow buffer. The shadow buffer
// is copied to the active buffer only while the scan sits in a dead slot, so
// a live digit never changes mid-frame.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   wr_valid   : write request, held until accepted
//   wr_value   : unsigned value to display
//   wr_ready   : block is idle and can accept a write
//   mux_sel    : current scan slot, 0 = least-significant digit
//   seg_out    : segment pattern for mux_sel ([6:0] = g..a, [7] = dp = 0)
//   busy       : conversion running or swap pending
//   overflow   : last accepted value was above MAX_VAL
module seven_seg_display_writer #(
  parameter int NUM_DIGITS = seven_seg_pkg::NUM_DIGITS,
  parameter int VAL_W      = 20,
  parameter int MAX_VAL    = seven_seg_pkg::MAX_VAL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  input  logic [VAL_W-1:0] wr_value,
  output logic             wr_ready,
  input  logic [2:0]       mux_sel,
  output logic [7:0]       seg_out,
  output logic             busy,
  output logic             overflow
);

  import seven_seg_pkg::*;

  state_e     state_q, state_d;
  logic       overflow_q, overflow_d;
  logic [6:0] shadow_q [NUM_DIGITS];
  logic [6:0] shadow_d [NUM_DIGITS];
  logic [6:0] active_q [NUM_DIGITS];
  logic [6:0] active_d [NUM_DIGITS];
  logic [6:0] blanked  [NUM_DIGITS];

  logic                    conv_start;
  logic                    conv_done;
  logic [4*NUM_DIGITS-1:0] conv_bcd;
  logic                    leading;
  logic                    slot_dead;

  seven_seg_bin2bcd #(
    .VAL_W  (VAL_W),
    .DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .value (wr_value),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Leading-zero suppression: walk from the top digit down and blank zeros
  // until the first non-zero digit. Digit 0 always shows, so 0 reads "0".
  always_comb begin
    leading = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      blanked[i] = bcd_to_seg(conv_bcd[4*i +: 4]);
      if ((i != 0) && leading && (conv_bcd[4*i +: 4] == 4'd0)) begin
        blanked[i] = SEG_BLANK;
      end else begin
        leading = 1'b0;
      end
    end
  end

  assign slot_dead = (int'(mux_sel) >= NUM_DIGITS);

  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    shadow_d   = shadow_q;
    active_d   = active_q;
    conv_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_valid) begin
          if (wr_value > VAL_W'(MAX_VAL)) begin
            for (int i = 0; i < NUM_DIGITS; i++) shadow_d[i] = SEG_DASH;
            overflow_d = 1'b1;
            state_d    = PENDING;
          end else begin
            conv_start = 1'b1;
            overflow_d = 1'b0;
            state_d    = CONVERT;
          end
        end
      end
      CONVERT: begin
        if (conv_done) state_d = BLANK;
      end
      BLANK: begin
        shadow_d = blanked;
        state_d  = PENDING;
      end
      PENDING: begin
        if (slot_dead) begin
          active_d = shadow_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      overflow_q <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= (i == 0) ? SEG_0 : SEG_BLANK;
        active_q[i] <= (i == 0) ? SEG_0 : SEG_BLANK;
      end
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
    end
  end

  assign wr_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign overflow = overflow_q;
  assign seg_out  = slot_dead ? 8'h00 : {1'b0, active_q[mux_sel]};

endmodule

// File: tb/tb_seven_seg_display_writer.sv
module tb_seven_seg_display_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic [19:0] wr_value;
  logic        wr_ready;
  logic [2:0]  mux_sel;
  logic [7:0]  seg_out;
  logic        busy;
  logic        overflow;

  typedef struct {
    logic [47:0] segs;
    logic        ovf;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          free_run = 1'b0;
  logic [47:0] cur_disp;

  seven_seg_display_writer dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_value (wr_value),
    .wr_ready (wr_ready),
    .mux_sel  (mux_sel),
    .seg_out  (seg_out),
    .busy     (busy),
    .overflow (overflow)
  );

  always #10 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'h3F;
      1: return 8'h06;
      2: return 8'h5B;
      3: return 8'h4F;
      4: return 8'h66;
      5: return 8'h6D;
      6: return 8'h7D;
      7: return 8'h07;
      8: return 8'h7F;
      default: return 8'h6F;
    endcase
  endfunction

  // Expected slot patterns, slot i in byte i, derived by decimal division.
  function automatic logic [47:0] model_disp(input int v);
    logic [47:0] r;
    int p;
    r = '0;
    if (v > 999999) begin
      for (int i = 0; i < 6; i++) r[8*i +: 8] = 8'h40;
      return r;
    end
    p = 1;
    for (int i = 0; i < 6; i++) begin
      if (i == 0 || v >= p) r[8*i +: 8] = seg_of((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic push_exp(input int v);
    exp_t e;
    e.segs = model_disp(v);
    e.ovf  = (v > 999999);
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    if (free_run) mux_sel = mux_sel + 3'd1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    free_run = 1'b1;
    while (wr_ready !== 1'b1 && n < 300) begin
      n++;
      tick();
    end
    if (n >= 300) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: wr_ready=%b after %0d cycles, want 1", wr_ready, n);
    end
  endtask

  // Pop the oldest expectation and sweep every scan slot against it.
  task automatic sb_check(input string tag);
    exp_t e;
    logic [7:0] want;
    if (sb_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s sb_empty: got no expectation, want one", tag);
      return;
    end
    e = sb_q.pop_front();
    free_run = 1'b0;
    for (int s = 0; s < 8; s++) begin
      mux_sel = 3'(s);
      #1;
      want = (s < 6) ? e.segs[8*s +: 8] : 8'h00;
      n_cmp++;
      if (seg_out !== want) begin
        n_bad++;
        $display("FAIL %s seg_slot%0d: got %h want %h", tag, s, seg_out, want);
      end
    end
    n_cmp++;
    if (overflow !== e.ovf) begin
      n_bad++;
      $display("FAIL %s overflow: got %b want %b", tag, overflow, e.ovf);
    end
    cur_disp = e.segs;
  endtask

  task automatic do_write(input int v, output int low_cycles);
    n_cmp++;
    if (wr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_write_ready: got %b want 1", wr_ready);
    end
    wr_valid = 1'b1;
    wr_value = 20'(v);
    push_exp(v);
    tick();
    wr_valid = 1'b0;
    wait_done(low_cycles);
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_valid = 1'b0; wr_value = '0; mux_sel = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (wr_ready !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got ready=%b busy=%b ovf=%b want 1 0 0", wr_ready, busy, overflow);
    end
    for (int s = 0; s < 8; s++) begin
      mux_sel = 3'(s);
      #1;
      n_cmp++;
      if (seg_out !== ((s == 0) ? 8'h3F : 8'h00)) begin
        n_bad++;
        $display("FAIL reset_slot%0d: got %h want %h", s, seg_out, (s == 0) ? 8'h3F : 8'h00);
      end
    end
    cur_disp = model_disp(0);
  endtask

  task automatic test_digits();
    int n;
    free_run = 1'b1;
    do_write(123456, n);
    n_cmp++;
    if (n < 22) begin
      n_bad++;
      $display("FAIL latency_123456: got %0d busy cycles want >= 22", n);
    end
    sb_check("val123456");
    do_write(42, n);
    sb_check("val42");
    do_write(0, n);
    sb_check("val0");
  endtask

  task automatic test_back_to_back();
    int n;
    free_run = 1'b1;
    wr_valid = 1'b1;
    wr_value = 20'd999999;
    push_exp(999999);
    tick();
    // A second request while busy must be ignored entirely.
    wr_value = 20'd111;
    repeat (5) begin
      tick();
      n_cmp++;
      if (wr_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_ready_busy: got %b want 0", wr_ready);
      end
    end
    wr_valid = 1'b0;
    wait_done(n);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_busy_idle: got %b want 0", busy);
    end
    sb_check("val999999");
  endtask

  task automatic test_tear();
    free_run = 1'b0;
    mux_sel  = 3'd2;
    wr_valid = 1'b1;
    wr_value = 20'd555;
    push_exp(555);
    tick();
    wr_valid = 1'b0;
    repeat (21) tick();
    repeat (4) begin
      tick();
      n_cmp++;
      if (busy !== 1'b1 || wr_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL tear_pending: got busy=%b ready=%b want 1 0", busy, wr_ready);
      end
      n_cmp++;
      if (seg_out !== cur_disp[16 +: 8]) begin
        n_bad++;
        $display("FAIL tear_slot2: got %h want %h", seg_out, cur_disp[16 +: 8]);
      end
    end
    mux_sel = 3'd6;
    #1;
    n_cmp++;
    if (wr_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL tear_preswap_ready: got %b want 0", wr_ready);
    end
    tick();
    n_cmp++;
    if (wr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL tear_postswap_ready: got %b want 1", wr_ready);
    end
    sb_check("tear555");
  endtask

  task automatic test_overflow();
    int n;
    free_run = 1'b1;
    do_write(1000000, n);
    sb_check("ovf1000000");
    do_write(7, n);
    sb_check("val7");
  endtask

  task automatic test_reset_mid();
    int n;
    free_run = 1'b0;
    mux_sel  = 3'd0;
    wr_valid = 1'b1;
    wr_value = 20'd314;
    push_exp(314);
    tick();
    repeat (9) tick();
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (wr_ready !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_ctrl: got ready=%b busy=%b ovf=%b want 1 0 0", wr_ready, busy, overflow);
    end
    n_cmp++;
    if (seg_out !== 8'h3F) begin
      n_bad++;
      $display("FAIL midrst_slot0: got %h want 3f", seg_out);
    end
    tick();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (wr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_release_ready: got %b want 1", wr_ready);
    end
    tick();
    n_cmp++;
    if (wr_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_held_accept: got ready=%b want 0", wr_ready);
    end
    wr_valid = 1'b0;
    wait_done(n);
    sb_check("midrst314");
  endtask

  initial begin
    test_reset();
    test_digits();
    test_back_to_back();
    test_tear();
    test_overflow();
    test_reset_mid();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: got %0d entries want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
